// File: rtl/tinybnn_pkg.sv
// Shared definitions for the parameter-chain loader.
// Contents:
//    state_t     - streamer FSM state encoding
//    WORD_BITS   - width of one parameter word on the input stream
//    chain_bits  - total serial bits on a daisy chain of neurons
package tinybnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int WORD_BITS = 8;

   function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
      return neurons * (inputs + bias_bits);
   endfunction

endpackage

// File: rtl/piso8.sv
// 8-bit parallel-in / serial-out shift register, MSB first.
// Ports:
//    clk    - clock, rising edge
//    reset  - synchronous active-high reset, clears the register
//    load   - capture data into the register
//    shift  - shift left by one, zero fill
//    data   - parallel word to capture
//    msb    - current serial bit (register bit 7)
module piso8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] data,
   output logic       msb
);

   logic [7:0] shift_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '0;
      end else if (load) begin
         shift_reg <= data;
      end else if (shift) begin
         shift_reg <= {shift_reg[6:0], 1'b0};
      end
   end

   assign msb = shift_reg[7];

endmodule

// File: rtl/param_streamer.sv
// Streams 8-bit parameter words onto the serial neuron parameter chain.
// Words arrive far-end first; each is serialized MSB first while setup is
// held high, and bits returning from the end of the chain are collected in
// readback.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; chain untouched
// LOAD   | in_ready high, waiting for the next parameter word
// SHIFT  | one bit per cycle onto the chain, setup high
// DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//    clk, reset      - clock and synchronous active-high reset
//    start           - begin loading the whole chain (honoured in IDLE only)
//    in_data/valid   - parameter word stream, in_ready handshake
//    setup           - shift enable to every neuron
//    param_out       - serial bit to the first neuron
//    param_in        - serial bit from the last neuron
//    busy, done      - load in progress / load complete pulse
//    readback        - last 8 bits seen on param_in, newest in bit 0
module param_streamer
   import tinybnn_pkg::*;
#(
   parameter int NEURONS   = 8,
   parameter int INPUTS    = 8,
   parameter int BIAS_BITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       setup,
   output logic       param_out,
   input  logic       param_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] readback
);

   localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
   localparam int CNT_W      = $clog2(CHAIN_BITS + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic             load_word;
   logic             last_bit;
   logic             ser_msb;

   // Final bit of the whole chain; a partial last word stops here, so its
   // unused low bits never reach the chain.
   assign last_bit = (bit_cnt == CNT_W'(CHAIN_BITS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         readback <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            bit_cnt <= '0;
            bit_idx <= '0;
         end
         if (load_word) begin
            bit_idx <= '0;
         end
         if (state == ST_SHIFT) begin
            bit_cnt  <= bit_cnt + CNT_W'(1);
            bit_idx  <= bit_idx + 3'd1;
            readback <= {readback[6:0], param_in};
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      setup     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      load_word = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_word = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            setup = 1'b1;
            if (last_bit)             state_nxt = ST_DONE;
            else if (bit_idx == 3'd7) state_nxt = ST_LOAD;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   piso8 u_piso8 (
      .clk   (clk),
      .reset (reset),
      .load  (load_word),
      .shift (setup),
      .data  (in_data),
      .msb   (ser_msb)
   );

   // Keep the chain input quiet outside SHIFT; a discarded partial word can
   // leave stale bits in the serializer.
   assign param_out = setup & ser_msb;

endmodule

// File: tb/tb_param_streamer.sv
module tb_param_streamer;

   typedef struct {
      int u;
      bit rnd;
      int nw;
      int pat;
      int exp_setup;
      int exp_lat;
   } scen_t;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   logic       rst_s      [2];
   logic       start_s    [2];
   logic       in_valid_s [2];
   logic [7:0] in_data_s  [2];
   logic       in_ready_s [2];
   logic       setup_s    [2];
   logic       pout_s     [2];
   logic       pin_s      [2];
   logic       busy_s     [2];
   logic       done_s     [2];
   logic [7:0] rb_s       [2];

   // Neuron chain emulation (u0: 1 neuron = 11 bits, u1: 8 neurons = 88 bits)
   logic [87:0] chain0 = '0;
   logic [87:0] chain1 = '0;
   logic [87:0] em0 = '0;
   logic [87:0] em1 = '0;
   logic        sh0 = 1'b0, sh1 = 1'b0, sb0 = 1'b0, sb1 = 1'b0;
   int          setup_cnt [2] = '{0, 0};
   int          ld_cnt    [2] = '{0, 0};
   int          done_cnt  [2] = '{0, 0};
   int          bad_cnt   [2] = '{0, 0};

   logic [7:0]  words [11];
   scen_t       tbl [6];

   assign pin_s[0] = chain0[10];
   assign pin_s[1] = chain1[87];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   param_streamer #(.NEURONS(1)) u_small (
      .clk(clk), .reset(rst_s[0]), .start(start_s[0]),
      .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .setup(setup_s[0]), .param_out(pout_s[0]), .param_in(pin_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .readback(rb_s[0])
   );

   param_streamer u_full (
      .clk(clk), .reset(rst_s[1]), .start(start_s[1]),
      .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .setup(setup_s[1]), .param_out(pout_s[1]), .param_in(pin_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .readback(rb_s[1])
   );

   // Sample DUT outputs mid-cycle
   always @(negedge clk) begin
      sh0 <= setup_s[0];
      sb0 <= pout_s[0];
      sh1 <= setup_s[1];
      sb1 <= pout_s[1];
      if (setup_s[0]) em0 <= {em0[86:0], pin_s[0]};
      if (setup_s[1]) em1 <= {em1[86:0], pin_s[1]};
      for (int u = 0; u < 2; u++) begin
         if (setup_s[u])                setup_cnt[u] <= setup_cnt[u] + 1;
         if (in_ready_s[u])             ld_cnt[u]    <= ld_cnt[u] + 1;
         if (done_s[u])                 done_cnt[u]  <= done_cnt[u] + 1;
         if (setup_s[u] && in_ready_s[u]) bad_cnt[u] <= bad_cnt[u] + 1;
      end
   end

   // Neurons shift on the same rising edge the streamer samples param_in
   always @(posedge clk) begin
      if (sh0) chain0 <= {77'b0, chain0[9:0], sb0};
      if (sh1) chain1 <= {chain1[86:0], sb1};
   end

   task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected chain: the first cb bits of the word stream, MSB of each word first
   function automatic logic [87:0] exp_chain(input int cb);
      logic [87:0] v;
      v = '0;
      for (int i = 0; i < cb; i++) v = {v[86:0], words[i / 8][7 - (i % 8)]};
      return v;
   endfunction

   function automatic logic [87:0] bit_mask(input int cb);
      logic [87:0] m;
      m = '0;
      for (int i = 0; i < cb; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic run_load(input int u, input int nw, input bit rnd, input int exp_setup,
                           input int exp_lat, input bit chk_em, input string tag);
      int s0, l0, d0, b0, c0, k, g, cb;
      bit v;
      logic [87:0] prev, m, ch, em;
      cb = (u == 1) ? 88 : 11;
      m  = bit_mask(cb);
      @(negedge clk);
      start_s[u] = 1'b1;
      c0 = cyc;
      s0 = setup_cnt[u]; l0 = ld_cnt[u]; d0 = done_cnt[u]; b0 = bad_cnt[u];
      prev = (u == 1) ? chain1 : chain0;
      @(negedge clk);
      start_s[u] = 1'b0;
      k = 0;
      g = 0;
      while (k < nw && g < 4000) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid_s[u] = v;
         in_data_s[u]  = v ? words[k] : 8'($urandom);
         if (v && in_ready_s[u]) k++;
         @(negedge clk);
         g++;
      end
      in_valid_s[u] = 1'b0;
      while (!done_s[u] && g < 4000) begin
         @(negedge clk);
         g++;
      end
      check({tag, " done_seen"}, 88'(done_s[u]), 88'(1));
      if (exp_lat >= 0) check({tag, " done_latency"}, 88'(cyc - c0), 88'(exp_lat));
      @(negedge clk);
      check({tag, " done_one_pulse"}, 88'(done_s[u]), 88'(0));
      check({tag, " busy_after"}, 88'(busy_s[u]), 88'(0));
      check({tag, " setup_cycles"}, 88'(setup_cnt[u] - s0), 88'(exp_setup));
      check({tag, " done_count"}, 88'(done_cnt[u] - d0), 88'(1));
      check({tag, " setup_in_load"}, 88'(bad_cnt[u] - b0), 88'(0));
      if (!rnd) check({tag, " load_cycles"}, 88'(ld_cnt[u] - l0), 88'(nw));
      ch = (u == 1) ? chain1 : chain0;
      check({tag, " chain"}, ch, exp_chain(cb));
      if (chk_em) begin
         em = (u == 1) ? em1 : em0;
         check({tag, " emerged"}, em & m, prev & m);
         check({tag, " readback"}, 88'(rb_s[u]), 88'(prev[7:0]));
      end
   endtask

   initial begin
      int n, g;
      for (int u = 0; u < 2; u++) begin
         rst_s[u] = 1'b1; start_s[u] = 1'b0; in_valid_s[u] = 1'b0; in_data_s[u] = '0;
      end
      tbl[0] = '{u: 0, rnd: 1'b0, nw: 2,  pat: 0, exp_setup: 11, exp_lat: 14};
      tbl[1] = '{u: 1, rnd: 1'b0, nw: 11, pat: 1, exp_setup: 88, exp_lat: 100};
      tbl[2] = '{u: 1, rnd: 1'b0, nw: 11, pat: 2, exp_setup: 88, exp_lat: 100};
      tbl[3] = '{u: 1, rnd: 1'b1, nw: 11, pat: 1, exp_setup: 88, exp_lat: -1};
      tbl[4] = '{u: 0, rnd: 1'b1, nw: 2,  pat: 1, exp_setup: 11, exp_lat: -1};
      tbl[5] = '{u: 1, rnd: 1'b1, nw: 11, pat: 2, exp_setup: 88, exp_lat: -1};

      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset in_ready", u), 88'(in_ready_s[u]), 88'(0));
         check($sformatf("u%0d reset setup", u), 88'(setup_s[u]), 88'(0));
         check($sformatf("u%0d reset param_out", u), 88'(pout_s[u]), 88'(0));
         check($sformatf("u%0d reset busy", u), 88'(busy_s[u]), 88'(0));
         check($sformatf("u%0d reset done", u), 88'(done_s[u]), 88'(0));
         check($sformatf("u%0d reset readback", u), 88'(rb_s[u]), 88'(0));
      end
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;

      for (int t = 0; t < 6; t++) begin
         if (tbl[t].pat == 0) begin
            words[0] = 8'hA5;
            words[1] = 8'hE0;
         end else if (tbl[t].pat == 1) begin
            for (int i = 0; i < 11; i++) words[i] = 8'($urandom);
         end else begin
            for (int i = 0; i < 11; i++) words[i] = ~words[i];
         end
         run_load(tbl[t].u, tbl[t].nw, tbl[t].rnd, tbl[t].exp_setup, tbl[t].exp_lat,
                  1'b1, $sformatf("scen%0d", t));
         if (tbl[t].pat == 0) begin
            check("n1 weights", 88'(chain0[10:3]), 88'(8'hA5));
            check("n1 bias", 88'(chain0[2:0]), 88'(3'b111));
         end
      end

      // start pulsed while shifting must not disturb the load
      for (int i = 0; i < 2; i++) words[i] = 8'($urandom);
      fork
         run_load(0, 2, 1'b0, 11, 14, 1'b1, "start_in_shift");
         begin
            g = 0;
            while (!setup_s[0] && g < 100) begin
               @(negedge clk);
               g++;
            end
            repeat (2) @(negedge clk);
            start_s[0] = 1'b1;
            @(negedge clk);
            start_s[0] = 1'b0;
         end
      join
      repeat (3) @(negedge clk);
      check("start_in_shift stays_idle", 88'(busy_s[0]), 88'(0));

      // reset on the 4th setup cycle
      for (int i = 0; i < 11; i++) words[i] = 8'($urandom);
      @(negedge clk);
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1]    = 1'b0;
      in_valid_s[1] = 1'b1;
      in_data_s[1]  = words[0];
      n = 0;
      g = 0;
      while (g < 50) begin
         if (setup_s[1]) n++;
         if (n == 4) break;
         @(negedge clk);
         g++;
      end
      check("rst_mid reached_4th_setup", 88'(n), 88'(4));
      rst_s[1]      = 1'b1;
      in_valid_s[1] = 1'b0;
      @(negedge clk);
      check("rst_mid setup", 88'(setup_s[1]), 88'(0));
      check("rst_mid busy", 88'(busy_s[1]), 88'(0));
      check("rst_mid in_ready", 88'(in_ready_s[1]), 88'(0));
      check("rst_mid done", 88'(done_s[1]), 88'(0));
      check("rst_mid readback", 88'(rb_s[1]), 88'(0));
      check("rst_mid param_out", 88'(pout_s[1]), 88'(0));
      rst_s[1] = 1'b0;
      run_load(1, 11, 1'b1, 88, -1, 1'b0, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
